// File: rtl/bus_ctrl.sv
// bus_ctrl: sequences RAM1 and UART accesses for the MEM stage.
// Ports: bci_* request/status inputs, bco_* strobes/results, bcio_ram1_data shared bus.
module bus_ctrl #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int          UART_WR_HOLD   = 2
) (
    input  logic        bci_clk,
    input  logic        bci_rst,
    input  logic        bci_req,
    input  logic        bci_we,
    input  logic [15:0] bci_addr,
    input  logic [15:0] bci_wdata,
    output logic [15:0] bco_rdata,
    output logic        bco_done,
    output logic        bco_busy,
    output logic        bco_ram1_en,
    output logic        bco_ram1_oe,
    output logic        bco_ram1_we,
    output logic [15:0] bco_ram1_addr,
    inout  wire  [15:0] bcio_ram1_data,
    input  logic        bci_uart_tbre,
    input  logic        bci_uart_tsre,
    input  logic        bci_uart_data_ready,
    output logic        bco_uart_wrn,
    output logic        bco_uart_rdn
);

    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_SRAM_RD      = 4'd1;
    localparam logic [3:0] S_SRAM_WR      = 4'd2;
    localparam logic [3:0] S_SRAM_WR_END  = 4'd3;
    localparam logic [3:0] S_UART_RD_WAIT = 4'd4;
    localparam logic [3:0] S_UART_RD1     = 4'd5;
    localparam logic [3:0] S_UART_RD2     = 4'd6;
    localparam logic [3:0] S_UART_WR      = 4'd7;
    localparam logic [3:0] S_UART_WR_TBRE = 4'd8;
    localparam logic [3:0] S_UART_WR_TSRE = 4'd9;
    localparam logic [3:0] S_DONE         = 4'd10;

    localparam logic [3:0] WR_HOLD = 4'(UART_WR_HOLD);

    logic [3:0]  state;
    logic [3:0]  state_n;
    logic [3:0]  cnt;
    logic [15:0] wdata_q;
    logic        drive;
    logic        is_data;
    logic        is_stat;
    logic        accept;

    assign is_data = (bci_addr == UART_DATA_ADDR);
    assign is_stat = (bci_addr == UART_STAT_ADDR);
    assign accept  = (state == S_IDLE) && bci_req;

    // Combinational so the scheduler stalls in the request cycle itself.
    assign bco_busy = ((state != S_IDLE) && (state != S_DONE)) || accept;

    assign bcio_ram1_data = drive ? wdata_q : 16'hzzzz;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (bci_req) begin
                    if (is_stat) begin
                        state_n = S_DONE;
                    end else if (is_data) begin
                        if (bci_we)
                            state_n = S_UART_WR;
                        else if (bci_uart_data_ready)
                            state_n = S_UART_RD1;
                        else
                            state_n = S_UART_RD_WAIT;
                    end else begin
                        state_n = bci_we ? S_SRAM_WR : S_SRAM_RD;
                    end
                end
            end
            S_SRAM_RD:      state_n = S_DONE;
            S_SRAM_WR:      state_n = S_SRAM_WR_END;
            S_SRAM_WR_END:  state_n = S_DONE;
            S_UART_RD_WAIT: if (bci_uart_data_ready) state_n = S_UART_RD1;
            S_UART_RD1:     state_n = S_UART_RD2;
            S_UART_RD2:     state_n = S_DONE;
            S_UART_WR:      if (cnt == 4'd1) state_n = S_UART_WR_TBRE;
            S_UART_WR_TBRE: if (bci_uart_tbre) state_n = S_UART_WR_TSRE;
            S_UART_WR_TSRE: if (bci_uart_tsre) state_n = S_DONE;
            S_DONE:         state_n = S_IDLE;
            default:        state_n = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each output is a
    // glitch-free function of the current state.
    always_ff @(posedge bci_clk or negedge bci_rst) begin
        if (!bci_rst) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            wdata_q       <= 16'h0000;
            bco_rdata     <= 16'h0000;
            bco_done      <= 1'b0;
            bco_ram1_addr <= 16'h0000;
            bco_ram1_en   <= 1'b1;
            bco_ram1_oe   <= 1'b1;
            bco_ram1_we   <= 1'b1;
            bco_uart_wrn  <= 1'b1;
            bco_uart_rdn  <= 1'b1;
            drive         <= 1'b0;
        end else begin
            state        <= state_n;
            bco_done     <= (state_n == S_DONE);
            bco_ram1_en  <= !((state_n == S_SRAM_RD) ||
                              (state_n == S_SRAM_WR) ||
                              (state_n == S_SRAM_WR_END));
            bco_ram1_oe  <= !(state_n == S_SRAM_RD);
            bco_ram1_we  <= !(state_n == S_SRAM_WR);
            bco_uart_rdn <= !((state_n == S_UART_RD1) ||
                              (state_n == S_UART_RD2));
            bco_uart_wrn <= !(state_n == S_UART_WR);
            drive        <= (state_n == S_SRAM_WR) ||
                            (state_n == S_SRAM_WR_END) ||
                            (state_n == S_UART_WR) ||
                            (state_n == S_UART_WR_TBRE);

            if (accept) begin
                wdata_q <= bci_wdata;
                if (!is_data && !is_stat)
                    bco_ram1_addr <= bci_addr;
                if (is_data && bci_we)
                    cnt <= WR_HOLD;
                if (is_stat && !bci_we)
                    bco_rdata <= {14'b0, bci_uart_data_ready,
                                  bci_uart_tbre & bci_uart_tsre};
            end

            if (state == S_UART_WR)
                cnt <= cnt - 4'd1;
            if (state == S_SRAM_RD)
                bco_rdata <= bcio_ram1_data;
            if (state == S_UART_RD2)
                bco_rdata <= {8'h00, bcio_ram1_data[7:0]};
        end
    end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Multi-cycle controller that sequences the shared RAM1 data bus and the on-board UART for the MEM stage. One registered state machine takes one access request at a time (load or store to a 16-bit address), drives the RAM1 and UART strobes, and returns read data with a one-cycle done pulse. While an access is in flight it holds a stall request to the scheduler. UART data and status are memory-mapped on the same bus.

## Interface
- UART_DATA_ADDR, 16'hBF00, UART data register address.
- UART_STAT_ADDR, 16'hBF01, UART status register address (read-only).
- UART_WR_HOLD, 2, number of cycles `bco_uart_wrn` is held low on a UART write (legal range 1-15).

Ports:
- bci_clk  in  1  system clock; all state changes on the rising edge.
- bci_rst  in  1  reset; asynchronous, active-low.
- bci_req  in  1  access request; level, held by requester until `bco_done`.
- bci_we  in  1  1 = write, 0 = read; sampled with `bci_req` in IDLE.
- bci_addr  in  16  access address; sampled in IDLE.
- bci_wdata  in  16  write data; sampled in IDLE.
- bco_rdata  out  16  read data; registered, valid from the `bco_done` cycle until the next read completes.
- bco_done  out  1  one-cycle completion pulse.
- bco_busy  out  1  stall request to the scheduler.
- bco_ram1_en / bco_ram1_oe / bco_ram1_we  out  1  RAM1 strobes, active-low.
- bco_ram1_addr  out  16  RAM1 address.
- bcio_ram1_data  inout  16  shared RAM1/UART data bus.
- bci_uart_tbre, bci_uart_tsre, bci_uart_data_ready  in  1  UART status inputs.
- bco_uart_wrn, bco_uart_rdn  out  1  UART strobes, active-low.

## Operation
- States: IDLE, SRAM_RD, SRAM_WR, SRAM_WR_END, UART_RD_WAIT, UART_RD1, UART_RD2, UART_WR, UART_WR_TBRE, UART_WR_TSRE, DONE.
- Inactive strobe levels: all strobes high, data bus Z.
  - Outside SRAM and UART access states the strobes sit at these levels.
  - `bco_ram1_en` is 0 only in SRAM states; it is 1 during all UART states.
- IDLE, `bci_req`=1: latch addr, wdata and we, then decode.
  - Read of UART_STAT_ADDR → DONE. `bco_rdata` loads {14'b0, data_ready, tbre&tsre}.
  - Read of UART_DATA_ADDR → UART_RD1 if `data_ready`=1, else UART_RD_WAIT.
  - Write to UART_DATA_ADDR → UART_WR. Internal counter loads UART_WR_HOLD.
  - Write to UART_STAT_ADDR is ignored → DONE.
  - Any other read → SRAM_RD. Any other write → SRAM_WR.
- SRAM_RD: en=0, oe=0, addr driven, bus Z. At the edge leaving this state, `bco_rdata` is captured from the bus → DONE.
- SRAM_WR: en=0, we=0, addr and data driven → SRAM_WR_END.
- SRAM_WR_END: we=1, en=0, addr and data still driven (hold) → DONE.
- UART_RD_WAIT: strobes inactive; stays until `data_ready`=1 → UART_RD1.
- UART_RD1 / UART_RD2: rdn=0, bus Z. At the edge leaving UART_RD2, `bco_rdata` is captured as {8'h00, bus[7:0]} → DONE.
- UART_WR: wrn=0, data driven, counter decrements. When the counter reaches 1 → UART_WR_TBRE (wrn=1, data still driven).
- UART_WR_TBRE: wait for `tbre`=1 → UART_WR_TSRE (bus Z).
- UART_WR_TSRE: wait for `tsre`=1 → DONE.
- DONE: `bco_done`=1, `bci_req` ignored → IDLE. A new request is accepted no earlier than the following IDLE cycle.
- `bco_busy` = (state ∉ {IDLE, DONE}) | (state==IDLE & `bci_req`). This is combinational so the scheduler stalls in the request cycle.
- Wait states have no timeout. A request waits indefinitely for UART status.

## Timing
- Reset, asynchronous and taking effect immediately, including mid-access:
  - state IDLE, `bco_rdata`=0, `bco_done`=0;
  - all strobes 1, bus Z, `bco_ram1_addr`=0, counter=0.
- Latency, with request accepted in cycle N (IDLE, `bci_req`=1); `bco_done` is high in:
  - status read: N+1;
  - SRAM read: N+2;
  - SRAM write: N+3;
  - UART read with data ready: N+3;
  - UART write: N+UART_WR_HOLD+3 at minimum, when tbre and tsre are already 1.
- Strobe and address outputs are registered functions of state, so they are glitch-free.
- Bus drive is enabled only in SRAM_WR, SRAM_WR_END, UART_WR and UART_WR_TBRE.
- `bci_req` dropped mid-access: the access still completes and `bco_done` still pulses.

## Test plan
- Reset mid-SRAM_WR (assert `bci_rst` low asynchronously) → same instant: `bco_ram1_we`=1, `bco_ram1_en`=1, bus Z, `bco_done`=0; after release, state is IDLE.
- SRAM write addr 16'h4000, data 16'hA5C3, then read of 16'h4000 with the model returning A5C3:
  - write: `bco_ram1_we` low exactly 1 cycle, `bco_done` at N+3;
  - read: `bco_rdata`=16'hA5C3 with `bco_done` at N+2;
  - `bco_busy` high from cycle N through N+1 (read) or N+2 (write).
- Read of 16'hBF01 with data_ready=1, tbre=1, tsre=0 → `bco_rdata`=16'h0002, `bco_done` at N+1, no strobe asserted.
- Read of 16'hBF00 with data_ready=0 for 5 cycles, then 1, UART returning 8'h41 → rdn low exactly 2 cycles; `bco_rdata`=16'h0041; `bco_busy` high throughout the wait.
- Write of 16'h0055 to 16'hBF00, tbre rising 4 cycles after wrn rises and tsre 3 cycles after that → wrn low UART_WR_HOLD=2 cycles; `bco_ram1_en`=1 throughout; `bco_done` one cycle after tsre is seen high.
- Back-to-back: `bci_req` held high across `bco_done` → second access accepted in the cycle after DONE, with no lost or duplicated done pulse.
